// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC register and IF/ID pipeline register.
//
// Ports:
//   Clk        - clock, all state updates on rising edge
//   Clrn       - asynchronous active-low reset
//   Stall      - hold PC and IF/ID (load-use hazard)
//   Pcsrc      - next-PC select: 00 seq, 01 branch, 10 jump, 11 register jump
//   Bpc/Jpc/Rpc- branch, jump and register-jump targets
//   Inst       - instruction word from instruction memory for Addr (same cycle)
//   Addr       - current PC, driven to instruction memory
//   D_Inst     - IF/ID instruction
//   D_Pc4      - IF/ID PC+4
//   D_Valid    - IF/ID holds a real instruction (0 = bubble)
//   Fetch_Cnt  - number of valid instructions delivered into IF/ID
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Stall,
    input  logic [1:0]  Pcsrc,
    input  logic [31:0] Bpc,
    input  logic [31:0] Jpc,
    input  logic [31:0] Rpc,
    input  logic [31:0] Inst,
    output logic [31:0] Addr,
    output logic [31:0] D_Inst,
    output logic [31:0] D_Pc4,
    output logic        D_Valid,
    output logic [31:0] Fetch_Cnt
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] d_inst, d_inst_nxt;
    logic [31:0] d_pc4, d_pc4_nxt;
    logic        d_valid, d_valid_nxt;
    logic [31:0] fetch_cnt, fetch_cnt_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        case (Pcsrc)
            2'b01:   target = Bpc;
            2'b10:   target = Jpc;
            default: target = Rpc;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        d_inst_nxt    = d_inst;
        d_pc4_nxt     = d_pc4;
        d_valid_nxt   = d_valid;
        fetch_cnt_nxt = fetch_cnt;
        case (state)
            BOOT: begin
                // One bubble cycle; redirect inputs are ignored here.
                state_nxt   = RUN;
                pc_nxt      = RESET_PC;
                d_inst_nxt  = '0;
                d_pc4_nxt   = '0;
                d_valid_nxt = 1'b0;
            end
            RUN: begin
                if (Pcsrc != 2'b00) begin
                    // Redirect wins over Stall; the word fetched this cycle is dropped.
                    pc_nxt      = target & ~32'h0000_0003;
                    d_inst_nxt  = '0;
                    d_pc4_nxt   = '0;
                    d_valid_nxt = 1'b0;
                end else if (!Stall) begin
                    pc_nxt        = pc_plus4;
                    d_inst_nxt    = Inst;
                    d_pc4_nxt     = pc_plus4;
                    d_valid_nxt   = 1'b1;
                    fetch_cnt_nxt = fetch_cnt + 32'd1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            d_inst    <= '0;
            d_pc4     <= '0;
            d_valid   <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            d_inst    <= d_inst_nxt;
            d_pc4     <= d_pc4_nxt;
            d_valid   <= d_valid_nxt;
            fetch_cnt <= fetch_cnt_nxt;
        end
    end

    assign Addr      = pc;
    assign D_Inst    = d_inst;
    assign D_Pc4     = d_pc4;
    assign D_Valid   = d_valid;
    assign Fetch_Cnt = fetch_cnt;

endmodule
